// File: rtl/win_scan_controller_pkg.sv
// Shared types, board geometry and the scan line table
// for the Connect Four win scan controller.
package win_scan_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int NLINES  = 25;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DONE
  } state_t;

  localparam logic [1:0] DIR_H  = 2'd0;
  localparam logic [1:0] DIR_V  = 2'd1;
  localparam logic [1:0] DIR_UR = 2'd2;
  localparam logic [1:0] DIR_UL = 2'd3;

  // dc is 3-bit two's complement so r_col + dc wraps
  // correctly for the up-left step of -1.
  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] dr;
    logic [2:0] dc;
    logic [2:0] len;
    logic [1:0] dir;
  } line_t;

  function automatic line_t line_info(
    input logic [4:0] l
  );
    line_t      li;
    logic [4:0] k;
    li = '0;
    k  = '0;
    unique case (1'b1)
      (l < 5'd6): begin
        li.row = l[2:0];
        li.dc  = 3'd1;
        li.len = 3'd7;
        li.dir = DIR_H;
      end
      (l >= 5'd6 && l < 5'd13): begin
        k      = l - 5'd6;
        li.col = k[2:0];
        li.dr  = 3'd1;
        li.len = 3'd6;
        li.dir = DIR_V;
      end
      (l >= 5'd13 && l < 5'd19): begin
        k      = l - 5'd13;
        li.dr  = 3'd1;
        li.dc  = 3'd1;
        li.dir = DIR_UR;
        case (k[2:0])
          3'd0: begin li.row = 3'd2; li.len = 3'd4; end
          3'd1: begin li.row = 3'd1; li.len = 3'd5; end
          3'd2: begin li.len = 3'd6; end
          3'd3: begin li.col = 3'd1; li.len = 3'd6; end
          3'd4: begin li.col = 3'd2; li.len = 3'd5; end
          default: begin li.col = 3'd3; li.len = 3'd4; end
        endcase
      end
      (l >= 5'd19): begin
        k      = l - 5'd19;
        li.dr  = 3'd1;
        li.dc  = 3'b111;
        li.dir = DIR_UL;
        case (k[2:0])
          3'd0: begin li.row = 3'd2; li.col = 3'd6; li.len = 3'd4; end
          3'd1: begin li.row = 3'd1; li.col = 3'd6; li.len = 3'd5; end
          3'd2: begin li.col = 3'd6; li.len = 3'd6; end
          3'd3: begin li.col = 3'd5; li.len = 3'd6; end
          3'd4: begin li.col = 3'd4; li.len = 3'd5; end
          default: begin li.col = 3'd3; li.len = 3'd4; end
        endcase
      end
      default: li = '0;
    endcase
    return li;
  endfunction

endpackage

// File: rtl/win_scan_controller_if.sv
// Handshake/board bundle between the game FSM (master)
// and the win scan controller (slave).
interface win_scan_controller_if;
  logic        start;
  logic        player;
  logic [41:0] board_p1;
  logic [41:0] board_p2;
  logic        busy;
  logic        done;
  logic        win;
  logic [1:0]  win_dir;

  modport master (
    output start, player, board_p1, board_p2,
    input  busy, done, win, win_dir
  );

  modport slave (
    input  start, player, board_p1, board_p2,
    output busy, done, win, win_dir
  );
endinterface

// File: rtl/win_scan_controller_winner_detection.sv
// Serial four-in-a-row detector: counts consecutive 1s.
// Ports: clock, reset (sync), i_data (cell bit), o_win.
module winner_detection (
  input  logic clock,
  input  logic reset,
  input  logic i_data,
  output logic o_win
);
  logic [2:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_data) begin
      if (r_cnt != 3'd4) r_cnt <= r_cnt + 3'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_win = (r_cnt == 3'd4);
endmodule

// File: rtl/win_scan_controller.sv
// Full-board win scan: streams every row, column and
// diagonal of one player's snapshot into the detector.
// Ports: clock, reset (sync, active-high), bus (slave):
//   start/player/board_p1/board_p2 in,
//   busy/done/win/win_dir out.
module win_scan_controller
  import win_scan_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  win_scan_controller_if.slave  bus
);
  state_t      r_state;
  logic [41:0] r_snap;
  logic [4:0]  r_line;
  logic [2:0]  r_row;
  logic [2:0]  r_col;
  logic [2:0]  r_cnt;
  logic        r_last;
  logic [1:0]  r_dir;
  logic        r_busy;
  logic        r_done;
  logic        r_win;
  logic [1:0]  r_wdir;

  line_t       w_info;
  line_t       w_next;
  line_t       w_first;
  logic [5:0]  w_idx;
  logic        w_bit;
  logic        w_det_rst;
  logic        w_det_data;
  logic        w_det_out;

  assign w_first = line_info(5'd0);
  assign w_info  = line_info(r_line);
  assign w_next  = line_info(r_line + 5'd1);

  assign w_idx = ({3'b0, r_row} * 6'd7) + {3'b0, r_col};
  assign w_bit = r_snap[w_idx];

  assign w_det_rst  = reset
                    | (r_state == IDLE)
                    | (r_state == CLEAR);
  assign w_det_data = (r_state == FEED) & w_bit;

  winner_detection u_det (
    .clock  (clock),
    .reset  (w_det_rst),
    .i_data (w_det_data),
    .o_win  (w_det_out)
  );

  // r_dir tracks the line being fed and is only updated
  // on CLEAR->FEED, so a run ending on the last cell of
  // a line is still attributed to that line in CLEAR.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_line  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_dir   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_win   <= 1'b0;
      r_wdir  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_snap  <= bus.player ? bus.board_p2
                                  : bus.board_p1;
            r_line  <= '0;
            r_row   <= w_first.row;
            r_col   <= w_first.col;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_win   <= 1'b0;
            r_wdir  <= '0;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          if (w_det_out) begin
            r_win   <= 1'b1;
            r_wdir  <= r_dir;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_dir   <= w_info.dir;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (w_det_out) begin
            r_win   <= 1'b1;
            r_wdir  <= r_dir;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == w_info.len - 3'd1) begin
            r_cnt   <= '0;
            r_state <= CLEAR;
            if (r_line == 5'(NLINES - 1)) begin
              r_last <= 1'b1;
            end else begin
              r_line <= r_line + 5'd1;
              r_row  <= w_next.row;
              r_col  <= w_next.col;
            end
          end else begin
            r_row <= r_row + w_info.dr;
            r_col <= r_col + w_info.dc;
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.win     = r_win;
  assign bus.win_dir = r_wdir;
endmodule

// File: tb/tb_win_scan_controller.sv
// Scoreboard bench for win_scan_controller: cycle of done,
// win and direction per scan, plus busy/reset behaviour.
module tb_win_scan_controller;
  import win_scan_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  win_scan_controller_if bus();

  win_scan_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         t;
    logic       win;
    logic [1:0] dir;
  } exp_s;

  exp_s sb[$];
  exp_s e;
  int   n_cmp = 0;
  int   n_err = 0;

  int         o_tdone;
  int         o_ndone;
  logic       o_win;
  logic [1:0] o_dir;
  logic       busy_tr [0:400];
  logic       win_tr  [0:400];

  // Cycle 0 is the cycle in which start is high.
  task automatic scan(
    input logic [41:0] b1,
    input logic [41:0] b2,
    input logic        p,
    input int          dup_at,
    input int          rst_at,
    input logic [41:0] b1_late
  );
    o_tdone = -1;
    o_ndone = 0;
    o_win   = 1'b0;
    o_dir   = 2'd0;
    for (int i = 0; i <= 400; i++) begin
      busy_tr[i] = 1'b0;
      win_tr[i]  = 1'b0;
    end
    @(negedge clock);
    busy_tr[0]   = bus.busy;
    bus.board_p1 = b1;
    bus.board_p2 = b2;
    bus.player   = p;
    bus.start    = 1'b1;
    for (int t = 1; t <= 400; t++) begin
      @(negedge clock);
      busy_tr[t] = bus.busy;
      win_tr[t]  = bus.win;
      if (bus.done) begin
        o_ndone++;
        if (o_tdone < 0) begin
          o_tdone = t;
          o_win   = bus.win;
          o_dir   = bus.win_dir;
        end
      end
      bus.start = (t == dup_at);
      reset     = (t == rst_at);
      if (t == dup_at) bus.board_p1 = b1_late;
      if (o_tdone >= 0 && t >= o_tdone + 3) break;
      if (rst_at >= 0 && t >= rst_at + 200) break;
    end
    bus.start = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset.busy got %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset.done got %b want 0", bus.done);
    end
    n_cmp++;
    if (bus.win !== 1'b0) begin
      n_err++;
      $display("FAIL reset.win got %b want 0", bus.win);
    end
    n_cmp++;
    if (bus.win_dir !== 2'd0) begin
      n_err++;
      $display("FAIL reset.dir got %0d want 0", bus.win_dir);
    end
    reset = 1'b0;
  endtask

  task automatic test_empty();
    sb.push_back('{171, 1'b0, 2'd0});
    scan('0, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t) begin
      n_err++;
      $display("FAIL empty.t got %0d want %0d", o_tdone, e.t);
    end
    n_cmp++;
    if (o_win !== e.win || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL empty.res got %b/%0d want %b/%0d",
               o_win, o_dir, e.win, e.dir);
    end
    n_cmp++;
    if (o_ndone !== 1) begin
      n_err++;
      $display("FAIL empty.ndone got %0d want 1", o_ndone);
    end
    n_cmp++;
    if ({busy_tr[0], busy_tr[1], busy_tr[171], busy_tr[172]}
        !== 4'b0110) begin
      n_err++;
      $display("FAIL empty.busy got %b%b%b%b want 0110",
               busy_tr[0], busy_tr[1], busy_tr[171],
               busy_tr[172]);
    end
  endtask

  task automatic test_row();
    sb.push_back('{7, 1'b1, DIR_H});
    scan(42'hF, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL row03 got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
    n_cmp++;
    if (win_tr[9] !== 1'b1) begin
      n_err++;
      $display("FAIL row03.hold got %b want 1", win_tr[9]);
    end
    sb.push_back('{10, 1'b1, DIR_H});
    scan(42'h78, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL row36 got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
  endtask

  task automatic test_col();
    logic [41:0] b;
    b = 42'h204081;
    sb.push_back('{55, 1'b1, DIR_V});
    scan('0, b, 1'b1, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL colp2 got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
    sb.push_back('{171, 1'b0, 2'd0});
    scan('0, b, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL colp1 got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
  endtask

  task automatic test_diag();
    logic [41:0] alt;
    alt = 42'h5B | (42'h5B << 14) | (42'h5B << 28);
    sb.push_back('{115, 1'b1, DIR_UR});
    scan(42'h1010101, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL diag_ur got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
    sb.push_back('{151, 1'b1, DIR_UL});
    scan(42'h1041040, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL diag_ul got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
    sb.push_back('{171, 1'b0, 2'd0});
    scan(alt, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL altrows got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
  endtask

  task automatic test_gap();
    sb.push_back('{171, 1'b0, 2'd0});
    scan(42'hF7, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL gap got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
  endtask

  task automatic test_dup_start();
    sb.push_back('{171, 1'b0, 2'd0});
    scan('0, '0, 1'b0, 20, -1, 42'hF);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL dup got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
    n_cmp++;
    if (o_ndone !== 1) begin
      n_err++;
      $display("FAIL dup.ndone got %0d want 1", o_ndone);
    end
  endtask

  task automatic test_reset_mid();
    sb.push_back('{-1, 1'b0, 2'd0});
    scan(42'hF << 21, '0, 1'b0, -1, 30, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_ndone !== 0) begin
      n_err++;
      $display("FAIL rstmid.done got t%0d n%0d want none",
               o_tdone, o_ndone);
    end
    n_cmp++;
    if ({busy_tr[30], busy_tr[31], win_tr[31]} !== 3'b100)
    begin
      n_err++;
      $display("FAIL rstmid.busy got %b%b%b want 100",
               busy_tr[30], busy_tr[31], win_tr[31]);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{7, 1'b1, DIR_H});
    scan(42'hF, '0, 1'b0, -1, -1, '0);
    e = sb.pop_front();
    n_cmp++;
    if (o_tdone !== e.t || o_win !== e.win
        || o_dir !== e.dir) begin
      n_err++;
      $display("FAIL b2b got t%0d %b/%0d want t%0d %b/%0d",
               o_tdone, o_win, o_dir, e.t, e.win, e.dir);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.player   = 1'b0;
    bus.board_p1 = '0;
    bus.board_p2 = '0;
    test_reset();
    test_empty();
    test_row();
    test_col();
    test_diag();
    test_gap();
    test_dup_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/win_scan_controller.md
Name: win_scan_controller

Overview:
Sequences a full-board win check for the 6x7 Connect Four board after every move. It snapshots one player's occupancy map, streams it cell by cell into the existing serial four-in-a-row detector (winner_detection) along every row, column and both diagonal families, and pulses the detector's reset between lines. It reports win/no-win and the direction of the winning line to the game FSM.

Parameters:
ROWS, 6, board rows; row 0 is the bottom row.
COLS, 7, board columns; column 0 is the leftmost column.
WIN_LEN, 4, run length that counts as a win; informational only, and must match the detector.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; clears the FSM and all outputs
start  in  1  one-cycle request to scan; ignored while busy=1
player  in  1  0 selects board_p1, 1 selects board_p2; sampled with start
board_p1  in  42  P1 occupancy; bit index = row*7+col
board_p2  in  42  P2 occupancy; same indexing
busy  out  1  high from the cycle after start through the DONE cycle
done  out  1  one-cycle pulse when the scan ends
win  out  1  result of the last scan; held until the next accepted start
win_dir  out  2  0 horizontal, 1 vertical, 2 diagonal up-right, 3 diagonal up-left; valid when win=1, else 0

Behaviour:
- Reset: FSM enters IDLE; busy=0, done=0, win=0, win_dir=0; detector held in reset.
- Detector interface: one serial data bit and one sync reset input. The detector output is combinational from its state, so out rises in the cycle after the 4th consecutive 1 is clocked in.
- States:
  - IDLE: detector held in reset.
  - CLEAR: detector reset asserted; out is still sampled this cycle.
  - FEED: one cell per cycle.
  - DONE: one cycle, then IDLE.
- IDLE, start=1: snapshot the selected board and player into registers, then go to CLEAR. In the next cycle win and win_dir are cleared and busy is set.
- Line order:
  - 6 rows: r=0..5, c=0..6.
  - 7 columns: c=0..6, r=0..5.
  - 6 up-right diagonals, starting at (2,0),(1,0),(0,0),(0,1),(0,2),(0,3), stepping r+1,c+1 until off-board.
  - 6 up-left diagonals, starting at (2,6),(1,6),(0,6),(0,5),(0,4),(0,3), stepping r+1,c-1 until off-board.
  - Diagonal line lengths are 4,5,6,6,5,4.
  - Totals: 25 lines, 144 cells.
- Per-line sequencing: one CLEAR cycle, then FEED for each cell of the line, with detector data = snapshot[row*7+col].
- After the last cell of a line:
  - Go to CLEAR for the next line.
  - After line 24, go to a final CLEAR, then to DONE.
- Detection: in FEED or CLEAR, detector out=1 means go to DONE with win=1 and win_dir = direction of the line that produced it. CLEAR checking covers a run that ends on the last cell of a line.
- No-win scan: 26 CLEAR + 144 FEED = 170 busy scan cycles; DONE in cycle 171 after the start cycle, with win=0.
- A start asserted while busy is dropped, not queued. Board inputs may change during a scan without effect, because the snapshot is used.
- Reset mid-scan: abort immediately to IDLE, drive outputs to their reset values, and do not pulse done.
- Counters: row and column are 3 bits; line index is 5 bits (0..24). Per-line start cell, step and length come from a constant table indexed by line.

Decomposition:
- Package win_scan_pkg holds:
  - the state enum {IDLE, CLEAR, FEED, DONE};
  - the direction constants DIR_H/DIR_V/DIR_UR/DIR_UL;
  - ROWS/COLS;
  - a function returning start row, start column, column step (-1/0/+1), row step and length for a line index 0..24.
- Single sub-module: instance of winner_detection; its reset = reset OR state is CLEAR/IDLE.

Test Plan:
- Empty boards, start in cycle 0 -> busy cycles 1-171, done in cycle 171 only, win=0, win_dir=0.
- board_p1 bits 0-3 (row 0, cols 0-3), player=0 -> done in cycle 7, win=1, win_dir=0.
- board_p1 bits 3-6 (row 0, cols 3-6) -> out rises in the CLEAR cycle (9); done in cycle 10, win=1, win_dir=0.
- board_p2 bits 0,7,14,21 (col 0, rows 0-3), player=1 -> done in cycle 55, win=1, win_dir=1. Same board with player=0 -> no win, done in cycle 171.
- Diagonals:
  - board_p1 bits 0,8,16,24 ((0,0)..(3,3)) -> win=1, win_dir=2.
  - bits 6,12,18,24 ((0,6)..(3,3)) -> win=1, win_dir=3.
  - Alternating rows with no four-run in any direction -> win=0.
- Robustness:
  - start pulsed again at cycle 20 -> ignored, single done.
  - reset at cycle 30 -> IDLE next cycle, busy=0, no done.
  - Row 0 = 1110111 -> no win; the detector must clear across the gap and across line boundaries.
